// File: rtl/clk_enable_gen_pkg.sv
// Shared types and helpers for the clk_enable_gen block.
// Includes the channel configuration record, the lock FSM states and the channel-index width.
package clk_enable_gen_pkg;

    // Config fields are sized for the widest supported ACC_W.
    // Narrower instances zero-extend into them, and synthesis trims the constant upper bits.
    localparam int ACC_W_MAX = 32;

    typedef struct packed {
        logic [ACC_W_MAX-1:0] inc;
        logic [ACC_W_MAX-1:0] mod;
        logic                 mode;
    } ch_cfg_t;

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/clk_enable_channel.sv
// One rational-rate enable channel.
// Contains a phase accumulator modulo cfg.mod plus registered ce/pseudo-clock outputs.
module clk_enable_channel
    import clk_enable_gen_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic    refclk,
    input  logic    rst,
    input  logic    ld,
    input  ch_cfg_t ld_cfg,
    input  logic    resync,
    output logic    ce_out,
    output logic    clk_out
);

    localparam int SUM_W = ACC_W_MAX + 1;

    ch_cfg_t          cfg_q, cfg_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ce_q, ce_d;
    logic             clk_q, clk_d;
    logic [SUM_W-1:0] inc_x, mod_x, sum;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        inc_x = {1'b0, cfg_q.inc};
        mod_x = {1'b0, cfg_q.mod};
        sum   = SUM_W'(acc_q) + inc_x;
        cfg_d = cfg_q;
        acc_d = acc_q;
        ce_d  = 1'b0;
        clk_d = clk_q;
        if (ld) begin
            cfg_d = ld_cfg;
            acc_d = '0;
            clk_d = 1'b0;
        end else if (resync) begin
            acc_d = '0;
            clk_d = 1'b0;
        end else if (cfg_q.mod == '0) begin
            acc_d = '0;
        end else if (inc_x >= mod_x) begin
            // The rate saturates at one enable per cycle, and the phase stays pinned at zero.
            acc_d = '0;
            ce_d  = 1'b1;
            clk_d = cfg_q.mode ? 1'b1 : ~clk_q;
        end else if (sum >= mod_x) begin
            acc_d = ACC_W'(sum - mod_x);
            ce_d  = 1'b1;
            clk_d = cfg_q.mode ? 1'b1 : ~clk_q;
        end else begin
            acc_d = ACC_W'(sum);
            clk_d = cfg_q.mode ? 1'b0 : clk_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge refclk) begin
        if (rst) begin
            cfg_q <= '0;
            acc_q <= '0;
            ce_q  <= 1'b0;
            clk_q <= 1'b0;
        end else begin
            cfg_q <= cfg_d;
            acc_q <= acc_d;
            ce_q  <= ce_d;
            clk_q <= clk_d;
        end
    end

    assign ce_out  = ce_q;
    assign clk_out = clk_q;

endmodule

// File: rtl/clk_enable_gen.sv
// Runtime-programmable multi-channel clock-enable generator on a single refclk.
// The top level holds the write decode, cfg_ack and the lock FSM, and instantiates one channel per output.
module clk_enable_gen
    import clk_enable_gen_pkg::*;
#(
    parameter int NUM_CH   = 7,
    parameter int ACC_W    = 16,
    parameter int LOCK_CYC = 16
) (
    input  logic                        refclk,
    input  logic                        rst,
    input  logic                        cfg_wr,
    input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
    input  logic [ACC_W-1:0]            cfg_inc,
    input  logic [ACC_W-1:0]            cfg_mod,
    input  logic                        cfg_mode,
    output logic                        cfg_ack,
    input  logic                        resync,
    output logic [NUM_CH-1:0]           ce_out,
    output logic [NUM_CH-1:0]           clk_out,
    output logic                        locked
);

    localparam int               CH_IDX_W = ch_idx_w(NUM_CH);
    localparam int               CNT_W    = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYC - 1);

    logic              cfg_valid;
    logic [NUM_CH-1:0] ld;
    ch_cfg_t           wr_cfg;
    lock_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ack_q, ack_d;

    always_comb begin
        cfg_valid   = cfg_wr && (32'(cfg_ch) < NUM_CH);
        wr_cfg.inc  = ACC_W_MAX'(cfg_inc);
        wr_cfg.mod  = ACC_W_MAX'(cfg_mod);
        wr_cfg.mode = cfg_mode;
        ld          = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ld[i] = cfg_valid && (cfg_ch == CH_IDX_W'(i));
        end
    end

    // Out-of-range writes are still acknowledged, but they never disturb the lock state.
    always_comb begin
        ack_d   = cfg_wr;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SETTLE: begin
                if (cfg_valid) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOCKED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOCKED: begin
                if (cfg_valid) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
        end
    end

    assign cfg_ack = ack_q;
    assign locked  = (state_q == LOCKED);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_enable_channel #(
            .ACC_W (ACC_W)
        ) u_ch (
            .refclk  (refclk),
            .rst     (rst),
            .ld      (ld[g]),
            .ld_cfg  (wr_cfg),
            .resync  (resync),
            .ce_out  (ce_out[g]),
            .clk_out (clk_out[g])
        );
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed self-checking bench for clk_enable_gen with NUM_CH=7, ACC_W=16 and LOCK_CYC=16.
// Cycle c counts from the refclk edge that samples the stimulus; outputs are sampled 1 ns after each edge.
module tb_clk_enable_gen;

    localparam int NUM_CH   = 7;
    localparam int ACC_W    = 16;
    localparam int LOCK_CYC = 16;
    localparam int CH_W     = 3;

    logic              refclk = 1'b0;
    logic              rst;
    logic              cfg_wr;
    logic [CH_W-1:0]   cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic [ACC_W-1:0]  cfg_mod;
    logic              cfg_mode;
    logic              cfg_ack;
    logic              resync;
    logic [NUM_CH-1:0] ce_out;
    logic [NUM_CH-1:0] clk_out;
    logic              locked;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 refclk = ~refclk;

    clk_enable_gen #(
        .NUM_CH   (NUM_CH),
        .ACC_W    (ACC_W),
        .LOCK_CYC (LOCK_CYC)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .cfg_wr   (cfg_wr),
        .cfg_ch   (cfg_ch),
        .cfg_inc  (cfg_inc),
        .cfg_mod  (cfg_mod),
        .cfg_mode (cfg_mode),
        .cfg_ack  (cfg_ack),
        .resync   (resync),
        .ce_out   (ce_out),
        .clk_out  (clk_out),
        .locked   (locked)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic set_wr(input int ch, input int inc, input int md, input logic mode);
        cfg_wr   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_inc  = ACC_W'(inc);
        cfg_mod  = ACC_W'(md);
        cfg_mode = mode;
    endtask

    initial begin
        int cnt;
        int exp_ce;
        int exp_clk;

        rst      = 1'b1;
        cfg_wr   = 1'b0;
        cfg_ch   = '0;
        cfg_inc  = '0;
        cfg_mod  = '0;
        cfg_mode = 1'b0;
        resync   = 1'b0;
        tick();
        tick();

        // Reset state and the initial lock interval
        check("rst_ce", ce_out, 0);
        check("rst_clk", clk_out, 0);
        check("rst_locked", locked, 0);
        check("rst_ack", cfg_ack, 0);
        rst = 1'b0;
        for (int k = 0; k <= LOCK_CYC + 2; k++) begin
            check($sformatf("init_locked k=%0d", k), locked, (k >= LOCK_CYC) ? 1 : 0);
            check($sformatf("init_ce k=%0d", k), ce_out, 0);
            tick();
        end

        // ch0: inc=1 mod=8 mode 0 -> a pulse every 8 cycles, clk_out period 16
        set_wr(0, 1, 8, 1'b0);
        tick();
        cfg_wr = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            exp_ce  = (c >= 9 && ((c - 1) % 8) == 0) ? 1 : 0;
            exp_clk = ((c - 1) / 8) % 2;
            check($sformatf("ch0_ack c=%0d", c), cfg_ack, (c == 1) ? 1 : 0);
            check($sformatf("ch0_ce c=%0d", c), ce_out[0], exp_ce);
            check($sformatf("ch0_clk c=%0d", c), clk_out[0], exp_clk);
            check($sformatf("ch0_locked c=%0d", c), locked, (c >= LOCK_CYC + 1) ? 1 : 0);
            check($sformatf("ch0_others c=%0d", c), ce_out[6:1], 0);
            tick();
        end

        // ch1: inc=3 mod=8 -> pulses after accumulation edges j%8 in {3,6,0}, 300 pulses in 800 cycles
        set_wr(1, 3, 8, 1'b0);
        tick();
        cfg_wr = 1'b0;
        cnt = 0;
        for (int c = 1; c <= 801; c++) begin
            if (c <= 40) begin
                exp_ce = (c >= 2 && (((c - 1) % 8) == 0 || ((c - 1) % 8) == 3 ||
                         ((c - 1) % 8) == 6)) ? 1 : 0;
                check($sformatf("ch1_ce c=%0d", c), ce_out[1], exp_ce);
            end
            if (c >= 2 && ce_out[1]) cnt++;
            tick();
        end
        check("ch1_count_800", cnt, 300);

        // ch2: inc=mod mode 1 every cycle; then back-to-back write to ch5 with inc=0
        set_wr(2, 8, 8, 1'b1);
        tick();
        check("ch2_ack1", cfg_ack, 1);
        check("ch2_ce_c1", ce_out[2], 0);
        check("ch2_clk_c1", clk_out[2], 0);
        set_wr(5, 0, 5, 1'b0);
        tick();
        cfg_wr = 1'b0;
        for (int c = 2; c <= 12; c++) begin
            check($sformatf("b2b_ack c=%0d", c), cfg_ack, (c == 2) ? 1 : 0);
            check($sformatf("ch2_ce c=%0d", c), ce_out[2], 1);
            check($sformatf("ch2_clk c=%0d", c), clk_out[2], 1);
            check($sformatf("ch5_inc0_ce c=%0d", c), ce_out[5], 0);
            tick();
        end
        set_wr(2, 8, 0, 1'b1);
        tick();
        cfg_wr = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            check($sformatf("ch2_off_ce c=%0d", c), ce_out[2], 0);
            check($sformatf("ch2_off_clk c=%0d", c), clk_out[2], 0);
            tick();
        end

        // ch0 and ch3: inc=1 mod=4, written out of phase, then locked, then resync
        set_wr(0, 1, 4, 1'b0);
        tick();
        cfg_wr = 1'b0;
        tick();
        tick();
        set_wr(3, 1, 4, 1'b0);
        tick();
        cfg_wr = 1'b0;
        repeat (30) tick();
        resync = 1'b1;
        tick();
        resync = 1'b0;
        check("rs_ce_all", ce_out, 0);
        check("rs_clk_all", clk_out, 0);
        // The first pulse follows the fourth accumulation edge after resync; an out-of-range write is issued at c=20.
        for (int c = 1; c <= 40; c++) begin
            exp_ce  = (c >= 5 && ((c - 1) % 4) == 0) ? 1 : 0;
            exp_clk = ((c - 1) / 4) % 2;
            check($sformatf("rs_ce0 c=%0d", c), ce_out[0], exp_ce);
            check($sformatf("rs_ce3 c=%0d", c), ce_out[3], exp_ce);
            check($sformatf("rs_clk0 c=%0d", c), clk_out[0], exp_clk);
            check($sformatf("rs_clk3 c=%0d", c), clk_out[3], exp_clk);
            check($sformatf("rs_hi_ce c=%0d", c), ce_out[6:4], 0);
            check($sformatf("rs_hi_clk c=%0d", c), clk_out[6:4], 0);
            check($sformatf("rs_locked c=%0d", c), locked, 1);
            check($sformatf("rs_ack c=%0d", c), cfg_ack, (c == 21) ? 1 : 0);
            if (c == 20) begin
                set_wr(7, 1, 2, 1'b1);
            end else begin
                cfg_wr = 1'b0;
            end
            tick();
        end

        // rst mid-stream together with a valid write: everything clears and no ack is generated
        set_wr(0, 1, 2, 1'b0);
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        cfg_wr = 1'b0;
        check("mid_rst_ce", ce_out, 0);
        check("mid_rst_clk", clk_out, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_ack", cfg_ack, 0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("post_rst_ce k=%0d", k), ce_out, 0);
            check($sformatf("post_rst_locked k=%0d", k), locked, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
